umips_stage_reg: RTL and testbench
==================================

Name: umips_stage_reg

Overview:
- Generic pipeline stage register for the umips core. It replaces the fixed-field, always-advancing inter-stage registers with a parametrised two-entry elastic stage.
- Carries a control bundle and a data bundle, and uses a valid/ready handshake.
- Supports synchronous flush and optional skid buffering, so stalls in a later stage never create a combinational ready path back through the pipeline.
- Forces control outputs to zero whenever the stage holds a bubble. Write enables therefore never fire on invalid slots.

Parameters:
- CTRL_W, 8: width of control bundle (reg_write, mem_write, mem_to_reg, sign/byte/word selects, ...).
- DATA_W, 101: width of data bundle (e.g. inst 32 + alu_out 32 + write_reg 5 + write_data 32).
- SKID, 1: 1 gives a 2-entry skid stage with registered in_ready. 0 gives a 1-entry stage with in_ready = !out_valid | out_ready.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- flush, input, 1: synchronous discard of all held entries.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept this cycle.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, DATA_W: upstream data bundle.
- out_valid, output, 1: output entry valid.
- out_ready, input, 1: downstream accepts this cycle.
- out_ctrl, output, CTRL_W: control bundle; all zero when out_valid=0.
- out_data, output, DATA_W: data bundle; don't-care when out_valid=0.
- occupancy, output, 2: number of entries held (0..2; never exceeds 1 when SKID=0).
- stall_cnt, output, CNT_W: saturating count of cycles with out_valid & !out_ready.

Behaviour:
- Reset (rst=0, asynchronous): all storage and out_data are 0, out_valid=0, out_ctrl=0, occupancy=0, stall_cnt=0. in_ready=1 when SKID=1 (registered). When SKID=0 it follows its equation (=1).
- Transfer rules: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready. Both can happen in one cycle.
- SKID=1 state machine, held in registers:
  - EMPTY: accept → FULL. in_ready=1.
  - FULL: accept & !consume → SKID. Consume & !accept → EMPTY. Both → FULL, with the new entry as main. Neither → hold.
  - SKID: in_ready=0. Consume → FULL, with the skid entry promoted to main.
- Output is driven only from the main register, never combinationally from in_*. Latency is 1 cycle from accept to out_valid.
- in_ready for SKID=1 is a flop: 1 in EMPTY and FULL, 0 in SKID. No combinational path from out_ready to in_ready.
- FIFO order is preserved. Throughput is 1 entry/cycle while out_ready=1.
- SKID=0 behaves as a single register: in_ready = !out_valid | out_ready. This is equivalent to the old always-advance stage when out_ready is tied 1.
- Flush:
  - On a cycle with flush=1, the next state is EMPTY and out_valid=0; occupancy=0 from the next cycle.
  - An input accepted in the same cycle is discarded.
  - An output consumed in the same cycle still counts as consumed downstream (the downstream handshake is unaffected).
  - Flush has priority over every other transition.
- Bubble masking: out_ctrl = main_ctrl & {CTRL_W{out_valid}}. Control registers are also cleared when a slot empties.
- stall_cnt: increments by 1 on each cycle with out_valid & !out_ready and saturates at 2^CNT_W-1. It is cleared only by reset, not by flush.
- Reset asserted mid-operation discards all entries immediately, with no completion of any pending handshake.
- X-safety: with in_valid=0, the in_ctrl and in_data values have no effect on state.

Decomposition:
- Shared package umips_pkg:
  - Stage state encoding: ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2.
  - Control bit index constants: CTL_REG_WRITE, CTL_MEM_WRITE, CTL_MEM_TO_REG, CTL_SIGN, CTL_BYTE, CTL_WORD.
  - Default widths.
- Sub-module umips_sat_counter (CNT_W, inc, count) for stall_cnt. It is reused by later performance counters.
- The stage core stays in one module. A generate branch selects SKID=0 or SKID=1.

Test Plan:
- Reset then stream, SKID=1, out_ready=1: feed ctrl 8'h05, data 1..4 on consecutive cycles. Expect out_valid one cycle later with data 1,2,3,4 in order, in_ready held at 1, stall_cnt=0.
- Backpressure fill: load A=0x11 and B=0x22, with out_ready=0 from the cycle after A is accepted. Expect occupancy 1→2, in_ready=0 the cycle after B is accepted, out_data holds 0x11, stall_cnt increments each stalled cycle. After out_ready=1, expect 0x11 then 0x22, then occupancy=0.
- Flush with simultaneous accept: occupancy=2, then flush=1 together with in_valid=1, data 0x33. Next cycle expect out_valid=0, out_ctrl=0, occupancy=0; 0x33 never appears.
- Bubble masking: in_ctrl=8'hFF with in_valid=0 for 5 cycles. Expect out_ctrl=0 throughout and no state change.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles. Expect stall_cnt=15 and then stable.
- Async reset mid-stall: occupancy=2, assert rst=0 between clock edges. Expect out_valid=0, out_ctrl=0 and occupancy=0 immediately, before the next edge. With SKID=0, expect in_ready=!out_valid|out_ready checked every cycle.

Source files
------------

// File: rtl/umips_pkg.sv
// umips_pkg: shared encodings and default widths for umips pipeline blocks
//   ST_*      : elastic stage state encoding (value equals entries held)
//   CTL_*     : bit positions inside the control bundle
//   UMIPS_*_W : default bundle and counter widths
package umips_pkg;
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } stage_st_t;
   localparam int CTL_REG_WRITE  = 0;
   localparam int CTL_MEM_WRITE  = 1;
   localparam int CTL_MEM_TO_REG = 2;
   localparam int CTL_SIGN       = 3;
   localparam int CTL_BYTE       = 4;
   localparam int CTL_WORD       = 5;
   localparam int UMIPS_CTRL_W   = 8;
   localparam int UMIPS_DATA_W   = 101;
   localparam int UMIPS_CNT_W    = 16;
endpackage

// File: rtl/umips_sat_counter.sv
// umips_sat_counter: saturating event counter
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, clears count
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module umips_sat_counter
   import umips_pkg::*;
#(
   parameter int CNT_W = UMIPS_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q, count_d;
   always_comb count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) count_q <= '0;
      else      count_q <= count_d;
   end
   assign count = count_q;
endmodule

// File: rtl/umips_stage_reg.sv
// umips_stage_reg: elastic valid/ready pipeline stage register with flush
//   clk, rst            : clock (rising) and asynchronous active-low reset
//   flush               : discard every held entry this cycle
//   in_valid/in_ready   : upstream handshake, in_ctrl/in_data payload
//   out_valid/out_ready : downstream handshake, out_ctrl/out_data payload
//   occupancy           : entries held (0..2)
//   stall_cnt           : saturating count of cycles stalled by downstream
module umips_stage_reg
   import umips_pkg::*;
#(
   parameter int CTRL_W = UMIPS_CTRL_W,
   parameter int DATA_W = UMIPS_DATA_W,
   parameter bit SKID   = 1'b1,
   parameter int CNT_W  = UMIPS_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);
   stage_st_t         state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic              accept, consume, stall_inc;

   assign out_valid = state_q != ST_EMPTY;
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;
   assign stall_inc = out_valid & ~out_ready;
   // Bubbles never present live control bits downstream
   assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
   assign out_data  = main_data_q;
   // State encoding doubles as the entry count
   assign occupancy = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
      end
   end

   generate
      if (SKID) begin : g_skid
         logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
         logic [DATA_W-1:0] skid_data_q, skid_data_d;
         logic              in_ready_q, in_ready_d;
         always_comb begin
            state_d     = state_q;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
            case (state_q)
               ST_EMPTY: if (accept) begin
                  state_d     = ST_FULL;
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end
               ST_FULL: if (accept && consume) begin
                  main_ctrl_d = in_ctrl;
                  main_data_d = in_data;
               end else if (accept) begin
                  state_d     = ST_SKID;
                  skid_ctrl_d = in_ctrl;
                  skid_data_d = in_data;
               end else if (consume) begin
                  state_d     = ST_EMPTY;
                  main_ctrl_d = '0;
               end
               ST_SKID: if (consume) begin
                  state_d     = ST_FULL;
                  main_ctrl_d = skid_ctrl_q;
                  main_data_d = skid_data_q;
                  skid_ctrl_d = '0;
               end
               default: state_d = ST_EMPTY;
            endcase
            if (flush) begin
               state_d     = ST_EMPTY;
               main_ctrl_d = '0;
               skid_ctrl_d = '0;
            end
            // Ready is derived from the next state so it can be registered
            in_ready_d = state_d != ST_SKID;
         end
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               skid_ctrl_q <= '0;
               skid_data_q <= '0;
               in_ready_q  <= 1'b1;
            end else begin
               skid_ctrl_q <= skid_ctrl_d;
               skid_data_q <= skid_data_d;
               in_ready_q  <= in_ready_d;
            end
         end
         assign in_ready = in_ready_q;
      end else begin : g_single
         always_comb begin
            state_d     = state_q;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            if (consume) begin
               state_d     = ST_EMPTY;
               main_ctrl_d = '0;
            end
            if (accept) begin
               state_d     = ST_FULL;
               main_ctrl_d = in_ctrl;
               main_data_d = in_data;
            end
            if (flush) begin
               state_d     = ST_EMPTY;
               main_ctrl_d = '0;
            end
         end
         assign in_ready = ~out_valid | out_ready;
      end
   endgenerate

   umips_sat_counter #(.CNT_W(CNT_W)) u_stall (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );
endmodule

// File: tb/tb_umips_stage_reg.sv
// tb_umips_stage_reg: checks skid, saturating-counter and single-entry variants against a queue model
module tb_umips_stage_reg;
   logic         clk, rst, flush, in_valid, out_ready;
   logic [7:0]   in_ctrl;
   logic [100:0] in_data;
   logic         in_ready, out_valid;
   logic [7:0]   out_ctrl;
   logic [100:0] out_data;
   logic [1:0]   occupancy;
   logic [15:0]  stall_cnt;
   logic         s_in_ready, s_out_valid;
   logic [7:0]   s_out_ctrl;
   logic [100:0] s_out_data;
   logic [1:0]   s_occupancy;
   logic [3:0]   s_stall_cnt;
   logic         z_in_ready, z_out_valid;
   logic [7:0]   z_out_ctrl;
   logic [100:0] z_out_data;
   logic [1:0]   z_occupancy;
   logic [15:0]  z_stall_cnt;

   umips_stage_reg #(.CTRL_W(8), .DATA_W(101), .SKID(1'b1), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt));
   umips_stage_reg #(.CTRL_W(8), .DATA_W(101), .SKID(1'b1), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_ctrl(s_out_ctrl), .out_data(s_out_data), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt));
   umips_stage_reg #(.CTRL_W(8), .DATA_W(101), .SKID(1'b0), .CNT_W(16)) u_one (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(z_out_valid), .out_ready(out_ready),
      .out_ctrl(z_out_ctrl), .out_data(z_out_data), .occupancy(z_occupancy), .stall_cnt(z_stall_cnt));

   typedef struct packed {logic [7:0] c; logic [100:0] d;} ent_t;
   typedef struct {
      logic iv; logic [100:0] d; logic ordy;
      logic ev, er; logic [1:0] eo; logic [100:0] ed; logic [15:0] es;
   } vec_t;

   ent_t q[$], q0[$];
   int   m_stall, m_stall4, m_stall0;
   int   n_chk, n_fail;
   vec_t tbl[11];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(bit iv, int d, bit o, bit ev, bit er, int eo, int ed, int es);
      vec_t r;
      r.iv = iv; r.d = 101'(d); r.ordy = o;
      r.ev = ev; r.er = er; r.eo = 2'(eo); r.ed = 101'(ed); r.es = 16'(es);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
      chk("occupancy", 128'(occupancy), 128'(q.size()));
      chk("out_ctrl", 128'(out_ctrl), q.size() != 0 ? 128'(q[0].c) : 128'd0);
      if (q.size() != 0) chk("out_data", 128'(out_data), 128'(q[0].d));
      if (!rst) chk("out_data_rst", 128'(out_data), 128'd0);
      chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
      chk("sat_stall_cnt", 128'(s_stall_cnt), 128'(m_stall4));
      chk("sat_out_valid", 128'(s_out_valid), 128'(q.size() != 0));
      chk("one_out_valid", 128'(z_out_valid), 128'(q0.size() != 0));
      chk("one_occupancy", 128'(z_occupancy), 128'(q0.size()));
      chk("one_in_ready", 128'(z_in_ready), 128'(q0.size() == 0 || out_ready));
      chk("one_out_ctrl", 128'(z_out_ctrl), q0.size() != 0 ? 128'(q0[0].c) : 128'd0);
      if (q0.size() != 0) chk("one_out_data", 128'(z_out_data), 128'(q0[0].d));
      chk("one_stall_cnt", 128'(z_stall_cnt), 128'(m_stall0));
   endtask

   task automatic cycle();
      bit   acc, cons, stl, acc0, cons0, stl0;
      ent_t e;
      e     = '{c: in_ctrl, d: in_data};
      acc   = in_valid && q.size() < 2;
      cons  = q.size() != 0 && out_ready;
      stl   = q.size() != 0 && !out_ready;
      acc0  = in_valid && (q0.size() == 0 || out_ready);
      cons0 = q0.size() != 0 && out_ready;
      stl0  = q0.size() != 0 && !out_ready;
      @(posedge clk);
      if (!rst) begin
         q.delete(); q0.delete();
         m_stall = 0; m_stall4 = 0; m_stall0 = 0;
      end else begin
         if (stl && m_stall < 65535) m_stall++;
         if (stl && m_stall4 < 15) m_stall4++;
         if (stl0 && m_stall0 < 65535) m_stall0++;
         if (cons) void'(q.pop_front());
         if (acc) q.push_back(e);
         if (flush) q.delete();
         if (cons0) void'(q0.pop_front());
         if (acc0) q0.push_back(e);
         if (flush) q0.delete();
      end
      #1;
      check_all();
   endtask

   task automatic drive(input bit iv, input int d, input bit o, input bit f);
      in_valid = iv; in_data = 101'(d); out_ready = o; flush = f;
   endtask

   initial begin
      logic [127:0] r;
      tbl[0]  = v(1, 1,     1, 1, 1, 1, 1,     0);
      tbl[1]  = v(1, 2,     1, 1, 1, 1, 2,     0);
      tbl[2]  = v(1, 3,     1, 1, 1, 1, 3,     0);
      tbl[3]  = v(1, 4,     1, 1, 1, 1, 4,     0);
      tbl[4]  = v(0, 0,     1, 0, 1, 0, 0,     0);
      tbl[5]  = v(1, 'h11,  1, 1, 1, 1, 'h11,  0);
      tbl[6]  = v(1, 'h22,  0, 1, 0, 2, 'h11,  1);
      tbl[7]  = v(0, 0,     0, 1, 0, 2, 'h11,  2);
      tbl[8]  = v(0, 0,     0, 1, 0, 2, 'h11,  3);
      tbl[9]  = v(0, 0,     1, 1, 1, 1, 'h22,  3);
      tbl[10] = v(0, 0,     1, 0, 1, 0, 0,     3);
      n_chk = 0; n_fail = 0;
      m_stall = 0; m_stall4 = 0; m_stall0 = 0;
      rst = 1'b0; in_ctrl = 8'h05;
      drive(0, 0, 1, 0);
      repeat (2) cycle();
      rst = 1'b1;
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].iv, int'(tbl[i].d), tbl[i].ordy, 0);
         cycle();
         chk($sformatf("tbl%0d_valid", i), 128'(out_valid), 128'(tbl[i].ev));
         chk($sformatf("tbl%0d_ready", i), 128'(in_ready), 128'(tbl[i].er));
         chk($sformatf("tbl%0d_occ", i), 128'(occupancy), 128'(tbl[i].eo));
         chk($sformatf("tbl%0d_ctrl", i), 128'(out_ctrl), tbl[i].ev ? 128'h05 : 128'h0);
         if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 128'(out_data), 128'(tbl[i].ed));
         chk($sformatf("tbl%0d_stall", i), 128'(stall_cnt), 128'(tbl[i].es));
      end
      drive(1, 'h44, 0, 0); cycle();
      drive(1, 'h55, 0, 0); cycle();
      chk("pre_flush_occ", 128'(occupancy), 128'd2);
      drive(1, 'h33, 0, 1); cycle();
      chk("flush_valid", 128'(out_valid), 128'd0);
      chk("flush_ctrl", 128'(out_ctrl), 128'd0);
      chk("flush_occ", 128'(occupancy), 128'd0);
      chk("flush_stall_kept", 128'(stall_cnt), 128'd5);
      drive(0, 0, 1, 0);
      repeat (3) begin
         cycle();
         chk("post_flush_valid", 128'(out_valid), 128'd0);
      end
      drive(1, 'h45, 1, 0); cycle();
      drive(1, 'h34, 1, 1); cycle();
      chk("flush_accept_valid", 128'(out_valid), 128'd0);
      chk("flush_accept_one_valid", 128'(z_out_valid), 128'd0);
      in_ctrl = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         drive(0, 'h5A5A + i, i[0], 0);
         cycle();
         chk("bubble_ctrl", 128'(out_ctrl), 128'd0);
         chk("bubble_occ", 128'(occupancy), 128'd0);
      end
      in_ctrl = 8'h05;
      drive(1, 'h66, 0, 0); cycle();
      drive(0, 0, 0, 0);
      repeat (20) cycle();
      chk("sat_15", 128'(s_stall_cnt), 128'd15);
      cycle();
      chk("sat_stable", 128'(s_stall_cnt), 128'd15);
      drive(1, 'h77, 0, 0); cycle();
      chk("pre_reset_occ", 128'(occupancy), 128'd2);
      drive(0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      q.delete(); q0.delete();
      m_stall = 0; m_stall4 = 0; m_stall0 = 0;
      chk("areset_valid", 128'(out_valid), 128'd0);
      chk("areset_ctrl", 128'(out_ctrl), 128'd0);
      chk("areset_occ", 128'(occupancy), 128'd0);
      chk("areset_ready", 128'(in_ready), 128'd1);
      chk("areset_stall", 128'(stall_cnt), 128'd0);
      check_all();
      cycle();
      rst = 1'b1;
      for (int i = 0; i < 400; i++) begin
         r = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_valid  = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         flush     = $urandom_range(0, 24) == 0;
         in_ctrl   = 8'($urandom());
         in_data   = r[100:0];
         cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
